// File: rtl/dw_conv_mac.sv
// Depthwise 3x3 MAC stage: drops border windows, then per channel multiplies,
// sums, adds bias and requantises to int8 over a fixed 4-stage pipeline.
module dw_conv_mac #(
  parameter int DATA_WIDTH      = 8,
  parameter int KERNEL_NUM      = 9,
  parameter int OUT_CHANNEL_NUM = 18,
  parameter int BIAS_WIDTH      = 16,
  parameter int ACC_WIDTH       = 21,
  parameter int COL_WIDTH       = 9,
  parameter int SHIFT_WIDTH     = 5
) (
  input  logic                                           clk,
  input  logic                                           rstn,
  input  logic [OUT_CHANNEL_NUM*KERNEL_NUM*DATA_WIDTH-1:0] win_in,
  input  logic                                           valid_in,
  input  logic                                           frame_start,
  input  logic                                           wt_wr_en,
  input  logic [$clog2(OUT_CHANNEL_NUM)-1:0]             wt_wr_addr,
  input  logic [KERNEL_NUM*DATA_WIDTH-1:0]               wt_wr_data,
  input  logic [BIAS_WIDTH-1:0]                          bias_wr_data,
  input  logic [COL_WIDTH-1:0]                           cfg_col_num,
  input  logic [COL_WIDTH-1:0]                           cfg_row_num,
  input  logic [SHIFT_WIDTH-1:0]                         cfg_shift,
  input  logic                                           cfg_relu,
  output logic [OUT_CHANNEL_NUM*DATA_WIDTH-1:0]          data_out,
  output logic                                           valid_out,
  output logic                                           frame_done
);
  localparam int AW = $clog2(OUT_CHANNEL_NUM);
  localparam int PW = 2 * DATA_WIDTH;
  localparam int WW = KERNEL_NUM * DATA_WIDTH;
  localparam int RW = ACC_WIDTH + (1 << SHIFT_WIDTH);
  localparam int GROUPS = KERNEL_NUM / 3;
  localparam longint SMAX = (longint'(1) << (DATA_WIDTH - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (DATA_WIDTH - 1));

  logic [COL_WIDTH-1:0] col_q, col_d, row_q, row_d, col_pos, row_pos;
  logic [3:0]           vld_q, vld_d, done_q, done_d;
  logic                 accept, last_pos;

  always_comb begin
    col_pos  = frame_start ? '0 : col_q;
    row_pos  = frame_start ? '0 : row_q;
    accept   = valid_in && (col_pos >= COL_WIDTH'(2)) && (row_pos >= COL_WIDTH'(2));
    last_pos = (col_pos == cfg_col_num - COL_WIDTH'(1)) && (row_pos == cfg_row_num - COL_WIDTH'(1));
    col_d    = col_pos;
    row_d    = row_pos;
    if (valid_in) begin
      if (col_pos == cfg_col_num - COL_WIDTH'(1)) begin
        col_d = '0;
        row_d = (row_pos == cfg_row_num - COL_WIDTH'(1)) ? '0 : row_pos + COL_WIDTH'(1);
      end else begin
        col_d = col_pos + COL_WIDTH'(1);
      end
    end
    vld_d  = {vld_q[2:0], accept};
    done_d = {done_q[2:0], accept && last_pos};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_q  <= '0;
      row_q  <= '0;
      vld_q  <= '0;
      done_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      vld_q  <= vld_d;
      done_q <= done_d;
    end
  end

  assign valid_out  = vld_q[3];
  assign frame_done = done_q[3];

  genvar gi;
  generate
    for (gi = 0; gi < OUT_CHANNEL_NUM; gi++) begin : g_ch
      logic signed [DATA_WIDTH-1:0] wt_q   [KERNEL_NUM];
      logic signed [DATA_WIDTH-1:0] wt_d   [KERNEL_NUM];
      logic signed [PW-1:0]         prod_q [KERNEL_NUM];
      logic signed [PW-1:0]         prod_d [KERNEL_NUM];
      logic signed [ACC_WIDTH-1:0]  psum_q [GROUPS];
      logic signed [ACC_WIDTH-1:0]  psum_d [GROUPS];
      logic signed [BIAS_WIDTH-1:0] bias_q, bias_d, bias1_q, bias1_d, bias2_q, bias2_d;
      logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
      logic signed [RW-1:0]         rnd, shifted;
      logic signed [DATA_WIDTH-1:0] out_q, out_d, sat;
      logic                         wr_hit;

      // Addresses beyond the last channel never match any gi, so they are ignored.
      assign wr_hit = wt_wr_en && (wt_wr_addr == AW'(gi));

      always_comb begin
        for (int k = 0; k < KERNEL_NUM; k++) begin
          wt_d[k]   = wr_hit ? $signed(wt_wr_data[k*DATA_WIDTH +: DATA_WIDTH]) : wt_q[k];
          prod_d[k] = PW'($signed(win_in[(gi*WW) + k*DATA_WIDTH +: DATA_WIDTH])) * PW'(wt_q[k]);
        end
        bias_d  = wr_hit ? $signed(bias_wr_data) : bias_q;
        // Bias travels with the window so a later write cannot touch it.
        bias1_d = bias_q;
        bias2_d = bias1_q;
        for (int j = 0; j < GROUPS; j++) begin
          psum_d[j] = ACC_WIDTH'(prod_q[3*j]) + ACC_WIDTH'(prod_q[3*j+1]) + ACC_WIDTH'(prod_q[3*j+2]);
        end
        acc_d = ACC_WIDTH'(bias2_q);
        for (int j = 0; j < GROUPS; j++) begin
          acc_d = acc_d + psum_q[j];
        end
        rnd = RW'(acc_q);
        if (cfg_shift != '0) begin
          rnd = rnd + (RW'(1) <<< (cfg_shift - SHIFT_WIDTH'(1)));
        end
        shifted = rnd >>> cfg_shift;
        if (shifted > RW'(SMAX))      sat = DATA_WIDTH'(SMAX);
        else if (shifted < RW'(SMIN)) sat = DATA_WIDTH'(SMIN);
        else                          sat = DATA_WIDTH'(shifted);
        if (cfg_relu && sat < 0) sat = '0;
        out_d = vld_q[2] ? sat : out_q;
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int k = 0; k < KERNEL_NUM; k++) begin
            wt_q[k]   <= '0;
            prod_q[k] <= '0;
          end
          for (int j = 0; j < GROUPS; j++) psum_q[j] <= '0;
          bias_q  <= '0;
          bias1_q <= '0;
          bias2_q <= '0;
          acc_q   <= '0;
          out_q   <= '0;
        end else begin
          wt_q    <= wt_d;
          prod_q  <= prod_d;
          psum_q  <= psum_d;
          bias_q  <= bias_d;
          bias1_q <= bias1_d;
          bias2_q <= bias2_d;
          acc_q   <= acc_d;
          out_q   <= out_d;
        end
      end

      assign data_out[gi*DATA_WIDTH +: DATA_WIDTH] = out_q;
    end
  endgenerate
endmodule

// File: tb/tb_dw_conv_mac.sv
// Directed scoreboard bench for dw_conv_mac: expected int8 vectors are queued as
// beats are accepted and popped/checked when valid_out appears.
module tb_dw_conv_mac;
  localparam int DW = 8, KN = 9, CH = 18, BW = 16, CW = 9, SW = 5;
  localparam int WINW = CH * KN * DW;

  logic             clk = 0, rstn = 0;
  logic [WINW-1:0]  win_in = '0;
  logic             valid_in = 0, frame_start = 0, wt_wr_en = 0;
  logic [4:0]       wt_wr_addr = '0;
  logic [KN*DW-1:0] wt_wr_data = '0;
  logic [BW-1:0]    bias_wr_data = '0;
  logic [CW-1:0]    cfg_col_num = 9'd4, cfg_row_num = 9'd4;
  logic [SW-1:0]    cfg_shift = '0;
  logic             cfg_relu = 0;
  logic [CH*DW-1:0] data_out;
  logic             valid_out, frame_done;

  dw_conv_mac dut (
    .clk(clk), .rstn(rstn), .win_in(win_in), .valid_in(valid_in),
    .frame_start(frame_start), .wt_wr_en(wt_wr_en), .wt_wr_addr(wt_wr_addr),
    .wt_wr_data(wt_wr_data), .bias_wr_data(bias_wr_data),
    .cfg_col_num(cfg_col_num), .cfg_row_num(cfg_row_num), .cfg_shift(cfg_shift),
    .cfg_relu(cfg_relu), .data_out(data_out), .valid_out(valid_out),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH*DW-1:0] data;
    logic             done;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  int cyc = 0, checks = 0, passes = 0, out_cnt = 0, done_cnt = 0;
  int m_col = 0, m_row = 0;
  int wt_m [CH][KN];
  int bias_m [CH];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] ref_out(int ch, logic [WINW-1:0] w);
    longint s;
    s = bias_m[ch];
    for (int k = 0; k < KN; k++)
      s += longint'($signed(w[(ch*KN+k)*DW +: DW])) * wt_m[ch][k];
    if (cfg_shift != 0) s = (s + (longint'(1) << (cfg_shift - 1))) >>> cfg_shift;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    if (cfg_relu && s < 0) s = 0;
    return DW'(s);
  endfunction

  function automatic logic [WINW-1:0] fill_win(int v);
    logic [WINW-1:0] w;
    for (int i = 0; i < CH*KN; i++) w[i*DW +: DW] = DW'(v);
    return w;
  endfunction

  function automatic logic [WINW-1:0] rand_win();
    logic [WINW-1:0] w;
    for (int i = 0; i < CH*KN; i++) w[i*DW +: DW] = DW'($urandom);
    return w;
  endfunction

  // Model the beat about to be sampled, then advance one clock.
  task automatic tick();
    exp_t e;
    if (frame_start) begin
      m_col = 0;
      m_row = 0;
    end
    if (valid_in) begin
      if (m_col >= 2 && m_row >= 2) begin
        for (int c = 0; c < CH; c++) e.data[c*DW +: DW] = ref_out(c, win_in);
        e.done = (m_row == int'(cfg_row_num) - 1) && (m_col == int'(cfg_col_num) - 1);
        e.cyc  = cyc;
        sb.push_back(e);
      end
      if (m_col == int'(cfg_col_num) - 1) begin
        m_col = 0;
        m_row = (m_row == int'(cfg_row_num) - 1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
    if (wt_wr_en && wt_wr_addr < CH) begin
      for (int k = 0; k < KN; k++) wt_m[wt_wr_addr][k] = int'($signed(wt_wr_data[k*DW +: DW]));
      bias_m[wt_wr_addr] = int'($signed(bias_wr_data));
    end
    @(posedge clk);
    #1;
    valid_in = 0;
    frame_start = 0;
    wt_wr_en = 0;
  endtask

  task automatic set_wr(int ch, int tv, int b, bit rnd);
    wt_wr_en = 1;
    wt_wr_addr = 5'(ch);
    for (int k = 0; k < KN; k++) wt_wr_data[k*DW +: DW] = rnd ? DW'($urandom) : DW'(tv);
    bias_wr_data = rnd ? BW'($urandom) : BW'(b);
  endtask

  task automatic write_all(int tv, int b, bit rnd);
    for (int c = 0; c < CH; c++) begin
      set_wr(c, tv, b, rnd);
      tick();
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    checks++;
    assert (sb.size() === 0) passes++;
    else $error("FAIL drain_timeout pending=%0d required=0", sb.size());
    repeat (2) tick();
  endtask

  task automatic run_frame(int rows, int cols, logic [WINW-1:0] w, bit rnd, string tag);
    cfg_row_num = CW'(rows);
    cfg_col_num = CW'(cols);
    out_cnt = 0;
    done_cnt = 0;
    for (int n = 0; n < rows*cols; n++) begin
      if (rnd) repeat ($urandom_range(0, 3)) tick();
      valid_in = 1;
      frame_start = (n == 0);
      win_in = rnd ? rand_win() : w;
      tick();
    end
    drain();
    checks += 2;
    assert (out_cnt === (rows-2)*(cols-2)) passes++;
    else $error("FAIL %s_count observed=%0d expected=%0d", tag, out_cnt, (rows-2)*(cols-2));
    assert (done_cnt === 1) passes++;
    else $error("FAIL %s_frame_done_count observed=%0d expected=1", tag, done_cnt);
    $display("frame %s rows=%0d cols=%0d outputs=%0d", tag, rows, cols, out_cnt);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      if (valid_out) begin
        out_cnt++;
        if (frame_done) done_cnt++;
        checks++;
        assert (sb.size() != 0) passes++;
        else $error("FAIL unexpected_valid_out observed=%h expected=none", data_out);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checks += 3;
          assert (data_out === e.data) passes++;
          else $error("FAIL data_out observed=%h expected=%h", data_out, e.data);
          assert (frame_done === e.done) passes++;
          else $error("FAIL frame_done observed=%b expected=%b", frame_done, e.done);
          assert (cyc === e.cyc + 4) passes++;
          else $error("FAIL latency observed=%0d expected=4", cyc - e.cyc);
          $display("out cyc=%0d ch0=%0d ch5=%0d done=%b", cyc, $signed(data_out[7:0]),
                   $signed(data_out[5*DW +: DW]), frame_done);
        end
      end else begin
        checks++;
        assert (frame_done === 1'b0) passes++;
        else $error("FAIL frame_done_without_valid observed=%b expected=0", frame_done);
      end
    end
  end

  initial begin
    for (int c = 0; c < CH; c++) begin
      bias_m[c] = 0;
      for (int k = 0; k < KN; k++) wt_m[c][k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    checks += 3;
    assert (data_out === '0) passes++;
    else $error("FAIL reset_data_out observed=%h expected=0", data_out);
    assert (valid_out === 1'b0) passes++;
    else $error("FAIL reset_valid_out observed=%b expected=0", valid_out);
    assert (frame_done === 1'b0) passes++;
    else $error("FAIL reset_frame_done observed=%b expected=0", frame_done);
    rstn = 1;
    tick();

    write_all(1, 0, 0);
    run_frame(4, 4, fill_win(1), 0, "basic");

    write_all(127, 0, 0);
    run_frame(3, 3, fill_win(127), 0, "sat_pos");
    write_all(-127, 0, 0);
    run_frame(3, 3, fill_win(127), 0, "sat_neg");
    cfg_relu = 1;
    run_frame(3, 3, fill_win(127), 0, "relu");
    cfg_relu = 0;

    write_all(1, 0, 0);
    cfg_shift = 5'd1;
    run_frame(3, 3, fill_win(1), 0, "round_pos");
    run_frame(3, 3, fill_win(-1), 0, "round_neg");
    cfg_shift = 5'd0;
    write_all(1, -20, 0);
    run_frame(3, 3, fill_win(1), 0, "bias_neg");

    write_all(0, 0, 0);
    set_wr(5, 2, 3, 0);
    tick();
    run_frame(3, 3, fill_win(1), 0, "ch5_only");

    // Out-of-range address must be ignored; a write coinciding with the
    // accepted beat must not affect that beat.
    set_wr(31, 99, 99, 0);
    tick();
    cfg_row_num = 9'd3;
    cfg_col_num = 9'd3;
    out_cnt = 0;
    done_cnt = 0;
    for (int n = 0; n < 9; n++) begin
      valid_in = 1;
      frame_start = (n == 0);
      win_in = fill_win(1);
      if (n == 8) set_wr(5, 7, 0, 0);
      tick();
    end
    drain();
    run_frame(3, 3, fill_win(1), 0, "ch5_new");

    write_all(0, 0, 1);
    cfg_shift = 5'd6;
    run_frame(5, 6, '0, 1, "gaps");
    cfg_shift = 5'd0;

    // Reset with two accepted beats still in the pipeline.
    write_all(1, 0, 0);
    cfg_row_num = 9'd3;
    cfg_col_num = 9'd4;
    for (int n = 0; n < 12; n++) begin
      valid_in = 1;
      frame_start = (n == 0);
      win_in = fill_win(1);
      tick();
    end
    rstn = 0;
    #1;
    sb.delete();
    m_col = 0;
    m_row = 0;
    for (int c = 0; c < CH; c++) begin
      bias_m[c] = 0;
      for (int k = 0; k < KN; k++) wt_m[c][k] = 0;
    end
    checks++;
    assert (valid_out === 1'b0) passes++;
    else $error("FAIL reset_mid_valid observed=%b expected=0", valid_out);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      assert (valid_out === 1'b0) passes++;
      else $error("FAIL flush_valid observed=%b expected=0", valid_out);
    end

    cfg_row_num = 9'd3;
    cfg_col_num = 9'd3;
    for (int n = 0; n < 2; n++) begin
      valid_in = 1;
      frame_start = (n == 0);
      win_in = fill_win(1);
      tick();
    end
    frame_start = 1;
    tick();
    out_cnt = 0;
    done_cnt = 0;
    for (int n = 0; n < 9; n++) begin
      valid_in = 1;
      win_in = fill_win(1);
      tick();
    end
    drain();
    checks += 2;
    assert (out_cnt === 1) passes++;
    else $error("FAIL restart_count observed=%0d expected=1", out_cnt);
    assert (data_out === '0) passes++;
    else $error("FAIL cleared_weights observed=%h expected=0", data_out);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/dw_conv_mac.md
Name: dw_conv_mac

Overview:
- Depthwise 3x3 compute stage directly downstream of the depthwise window pre-processor.
- Consumes one 3x3 window per channel per beat and tracks column/row position to drop border (incomplete) windows.
- Per channel: 9 signed multiplies, adds a bias, then rounds, shifts, saturates and optionally applies ReLU to int8.
- Feeds the next layer's pre-processor or the output buffer, one int8 per channel per valid beat.

Parameters:
- DATA_WIDTH, 8, activation/weight width (signed).
- KERNEL_NUM, 9, taps per window (3x3).
- OUT_CHANNEL_NUM, 18, channels processed in parallel.
- BIAS_WIDTH, 16, signed bias width.
- ACC_WIDTH, 21, accumulator width; holds 9 products plus bias without overflow.
- COL_WIDTH, 9, width of the column/row count configs; covers 320.
- SHIFT_WIDTH, 5, requant right-shift amount width.

Ports:
- clk, input, 1, clock.
- rstn, input, 1, asynchronous active-low reset.
- win_in, input, OUT_CHANNEL_NUM*KERNEL_NUM*DATA_WIDTH, windows. Channel c at [c*KERNEL_NUM*DATA_WIDTH +: KERNEL_NUM*DATA_WIDTH]; tap k at [k*DATA_WIDTH +: DATA_WIDTH] within it; tap 0 = top-left, row-major.
- valid_in, input, 1, win_in beat valid.
- frame_start, input, 1, synchronous clear of position counters.
- wt_wr_en, input, 1, weight/bias write strobe.
- wt_wr_addr, input, $clog2(OUT_CHANNEL_NUM), channel being written.
- wt_wr_data, input, KERNEL_NUM*DATA_WIDTH, 9 signed taps, same tap order as win_in.
- bias_wr_data, input, BIAS_WIDTH, signed bias for that channel.
- cfg_col_num, input, COL_WIDTH, input columns per row (>=3).
- cfg_row_num, input, COL_WIDTH, input rows per frame (>=3).
- cfg_shift, input, SHIFT_WIDTH, requant right shift.
- cfg_relu, input, 1, clamp negatives to 0.
- data_out, output, OUT_CHANNEL_NUM*DATA_WIDTH, int8 results; channel c at [c*DATA_WIDTH +: DATA_WIDTH].
- valid_out, output, 1, data_out valid.
- frame_done, output, 1, pulse coincident with the last valid output of a frame.

Behaviour:
- Reset: data_out=0, valid_out=0, frame_done=0, all weights/biases=0, counters=0, pipeline valids cleared.
- Reset mid-frame flushes in-flight beats; no output appears for them.
- Position counters advance only on valid_in.
  - col_cnt counts 0..cfg_col_num-1, then wraps to 0; row_cnt increments on the wrap.
  - row_cnt wraps to 0 after cfg_row_num-1 with col wrap.
- frame_start clears both counters. If frame_start and valid_in occur together, that beat is position (0,0).
- Window accepted when valid_in && col_cnt>=2 && row_cnt>=2; other beats are discarded.
- Valid frame yields (cfg_row_num-2)*(cfg_col_num-2) outputs.
- Weight write: on wt_wr_en, taps and bias of channel wt_wr_addr update at the clock edge.
  - A window captured at stage 1 in the same cycle uses the old values.
  - wt_wr_addr >= OUT_CHANNEL_NUM is ignored.
- Pipeline, fixed latency 4 cycles from accepted valid_in to valid_out, no backpressure, one beat per cycle:
  - S1: 9 signed 8x8 products per channel, registered (16 bit).
  - S2: three 3-term partial sums, registered.
  - S3: final sum plus sign-extended bias to ACC_WIDTH, registered.
  - S4: rounding, shift, saturation, ReLU; drives data_out/valid_out.
- S4 arithmetic:
  - If cfg_shift>0, add 1<<(cfg_shift-1), then arithmetic shift right by cfg_shift; if cfg_shift=0, pass through.
  - Saturate to [-128,127].
  - If cfg_relu, negatives become 0.
- cfg_* values are sampled per stage and must be static during a frame.
- data_out holds its last value when valid_out=0.
- frame_done=1 together with valid_out for the window accepted at (cfg_row_num-1, cfg_col_num-1).

Test Plan:
- Reset, all taps=1, bias=0, shift=0, window all 1s, cfg 4x4 frame of 16 beats -> exactly 4 valid_out; each data_out channel = 9; first valid_out 4 cycles after the beat at (2,2); frame_done on the 4th output.
- Window all 127, weights all 127, shift=0 -> sum 145161 saturates to 127; negate weights (-127) -> -128; same with cfg_relu=1 -> 0.
- Rounding, taps=1, window 1s, shift=1: bias 0 -> (9+1)>>1=5. Window -1s -> (-9+1)>>>1 = -4. bias=-20 with 1s window, shift=0 -> -11.
- Per-channel independence: write channel 5 taps=2, bias=3, others 0 -> ch5 = 21, all other channels 0.
- valid_in gaps of random length within a 5x6 frame -> output count 12, values unchanged, latency always 4 cycles after the accepted beat.
- Assert rstn mid-frame with 2 beats in flight -> no valid_out afterwards, weights read back as 0 (output 0 for bias 0). frame_start alone restarts counting at (0,0).
